// File: rtl/gmii_udp_rx.sv
// gmii_udp_rx: GMII receive parser. Filters Ethernet/IPv4/UDP frames by MAC, IP and
// port, and streams the matching UDP payload into the RX packet SRAM from address 0.
module gmii_udp_rx #(
  parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
  parameter logic [31:0] IP_ADDR  = 32'hC0A8_000A,
  parameter logic [15:0] UDP_PORT = 16'd1234,
  parameter int          ADDR_W   = 10
) (
  input  logic              RX_CLK,
  input  logic              rst,
  input  logic              RX_DV,
  input  logic [7:0]        RXD,
  input  logic              RX_ER,
  output logic              rx_udp_data_vb,
  output logic [7:0]        rx_udp_data,
  output logic [ADDR_W-1:0] rx_addr,
  output logic              wmask0,
  output logic [15:0]       rx_udp_len,
  output logic              rx_irq,
  output logic [7:0]        rx_drop_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    ETH_HDR,
    IP_HDR,
    UDP_HDR,
    PAYLOAD,
    DROP
  } state_t;

  localparam int          CNT_W       = ADDR_W + 1;
  localparam logic [15:0] MAX_UDP_LEN = 16'(8 + (1 << ADDR_W));

  state_t           state_reg;
  logic [4:0]       byte_cnt_reg;
  logic             uni_ok_reg;
  logic             bcast_ok_reg;
  logic             armed_reg;
  logic [7:0]       len_hi_reg;
  logic [CNT_W-1:0] pay_len_reg;
  logic [CNT_W-1:0] pay_cnt_reg;
  logic             done_pend_reg;

  logic [7:0]  mac_bytes [0:7];
  logic [7:0]  ip_bytes  [0:3];
  logic        hdr_fail;
  logic        uni_ok_next;
  logic        bcast_ok_next;
  logic [15:0] udp_len;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mac
      if (gi < 6) begin : g_byte
        assign mac_bytes[gi] = MAC_ADDR[47-8*gi -: 8];
      end else begin : g_pad
        assign mac_bytes[gi] = 8'h00;
      end
    end
    for (gi = 0; gi < 4; gi++) begin : g_ip
      assign ip_bytes[gi] = IP_ADDR[31-8*gi -: 8];
    end
  endgenerate

  assign udp_len = {len_hi_reg, RXD};

  // Per-byte header checks; unicast and broadcast MAC matches are tracked in parallel
  // so a frame fails on the first byte that rules out both.
  always_comb begin
    hdr_fail      = 1'b0;
    uni_ok_next   = uni_ok_reg;
    bcast_ok_next = bcast_ok_reg;
    case (state_reg)
      PREAMBLE: hdr_fail = (RXD != 8'h55) && (RXD != 8'hD5);
      ETH_HDR: begin
        if (byte_cnt_reg < 5'd6) begin
          uni_ok_next   = uni_ok_reg && (RXD == mac_bytes[byte_cnt_reg[2:0]]);
          bcast_ok_next = bcast_ok_reg && (RXD == 8'hFF);
          hdr_fail      = !uni_ok_next && !bcast_ok_next;
        end else if (byte_cnt_reg == 5'd12) begin
          hdr_fail = (RXD != 8'h08);
        end else if (byte_cnt_reg == 5'd13) begin
          hdr_fail = (RXD != 8'h00);
        end
      end
      IP_HDR: begin
        if (byte_cnt_reg == 5'd0) begin
          hdr_fail = (RXD != 8'h45);
        end else if (byte_cnt_reg == 5'd9) begin
          hdr_fail = (RXD != 8'h11);
        end else if (byte_cnt_reg >= 5'd16) begin
          hdr_fail = (RXD != ip_bytes[byte_cnt_reg[1:0]]);
        end
      end
      UDP_HDR: begin
        if (byte_cnt_reg == 5'd2) begin
          hdr_fail = (RXD != UDP_PORT[15:8]);
        end else if (byte_cnt_reg == 5'd3) begin
          hdr_fail = (RXD != UDP_PORT[7:0]);
        end else if (byte_cnt_reg == 5'd5) begin
          hdr_fail = (udp_len < 16'd8) || (udp_len > MAX_UDP_LEN);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      byte_cnt_reg   <= '0;
      uni_ok_reg     <= 1'b0;
      bcast_ok_reg   <= 1'b0;
      armed_reg      <= 1'b0;
      len_hi_reg     <= '0;
      pay_len_reg    <= '0;
      pay_cnt_reg    <= '0;
      done_pend_reg  <= 1'b0;
      rx_udp_data_vb <= 1'b1;
      rx_udp_data    <= '0;
      rx_addr        <= '0;
      wmask0         <= 1'b0;
      rx_udp_len     <= '0;
      rx_irq         <= 1'b0;
      rx_drop_cnt    <= '0;
    end else begin
      rx_udp_data_vb <= 1'b1;
      wmask0         <= 1'b0;
      rx_irq         <= done_pend_reg;
      done_pend_reg  <= 1'b0;
      if (done_pend_reg) begin
        rx_udp_len <= 16'(pay_len_reg);
      end
      // After reset, a frame already in flight must not be taken as a new start.
      if (!RX_DV) begin
        armed_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (RX_DV) begin
            state_reg <= (armed_reg && RXD == 8'h55) ? PREAMBLE : DROP;
          end
        end
        DROP: begin
          if (!RX_DV) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          if (!RX_DV || RX_ER || hdr_fail) begin
            rx_drop_cnt <= (rx_drop_cnt == 8'hFF) ? rx_drop_cnt : rx_drop_cnt + 8'd1;
            state_reg   <= RX_DV ? DROP : IDLE;
          end else begin
            case (state_reg)
              PREAMBLE: begin
                if (RXD == 8'hD5) begin
                  state_reg    <= ETH_HDR;
                  byte_cnt_reg <= '0;
                  uni_ok_reg   <= 1'b1;
                  bcast_ok_reg <= 1'b1;
                end
              end
              ETH_HDR: begin
                uni_ok_reg   <= uni_ok_next;
                bcast_ok_reg <= bcast_ok_next;
                if (byte_cnt_reg == 5'd13) begin
                  state_reg    <= IP_HDR;
                  byte_cnt_reg <= '0;
                end else begin
                  byte_cnt_reg <= byte_cnt_reg + 5'd1;
                end
              end
              IP_HDR: begin
                if (byte_cnt_reg == 5'd19) begin
                  state_reg    <= UDP_HDR;
                  byte_cnt_reg <= '0;
                end else begin
                  byte_cnt_reg <= byte_cnt_reg + 5'd1;
                end
              end
              UDP_HDR: begin
                byte_cnt_reg <= byte_cnt_reg + 5'd1;
                if (byte_cnt_reg == 5'd4) begin
                  len_hi_reg <= RXD;
                end
                if (byte_cnt_reg == 5'd5) begin
                  pay_len_reg <= CNT_W'(udp_len - 16'd8);
                end
                if (byte_cnt_reg == 5'd7) begin
                  pay_cnt_reg <= '0;
                  if (pay_len_reg == '0) begin
                    done_pend_reg <= 1'b1;
                    state_reg     <= DROP;
                  end else begin
                    state_reg <= PAYLOAD;
                  end
                end
              end
              PAYLOAD: begin
                rx_udp_data_vb <= 1'b0;
                wmask0         <= 1'b1;
                rx_udp_data    <= RXD;
                rx_addr        <= pay_cnt_reg[ADDR_W-1:0];
                pay_cnt_reg    <= pay_cnt_reg + CNT_W'(1);
                // Trailing padding and FCS are sunk in DROP without counting.
                if (pay_cnt_reg == pay_len_reg - CNT_W'(1)) begin
                  done_pend_reg <= 1'b1;
                  state_reg     <= DROP;
                end
              end
              default: state_reg <= DROP;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_udp_rx.sv
// Testbench for gmii_udp_rx: table of frames plus hand-written multi-frame and
// mid-payload reset sequences, checked against a write/irq scoreboard.
module tb_gmii_udp_rx;

  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [31:0] IP    = 32'hC0A8_000A;
  localparam int          AW    = 10;
  localparam int          HDR_BYTES = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic          RX_DV;
  logic [7:0]    RXD;
  logic          RX_ER;
  logic          rx_udp_data_vb;
  logic [7:0]    rx_udp_data;
  logic [AW-1:0] rx_addr;
  logic          wmask0;
  logic [15:0]   rx_udp_len;
  logic          rx_irq;
  logic [7:0]    rx_drop_cnt;

  gmii_udp_rx dut (
    .RX_CLK(clk),
    .rst(rst),
    .RX_DV(RX_DV),
    .RXD(RXD),
    .RX_ER(RX_ER),
    .rx_udp_data_vb(rx_udp_data_vb),
    .rx_udp_data(rx_udp_data),
    .rx_addr(rx_addr),
    .wmask0(wmask0),
    .rx_udp_len(rx_udp_len),
    .rx_irq(rx_irq),
    .rx_drop_cnt(rx_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] port;
    logic [15:0] etype;
    logic [7:0]  proto;
    int          ulen;
    int          send_pay;
    int          pad;
    int          er_at;
    int          exp_writes;
    bit          exp_irq;
    int          exp_len;
    int          exp_drop;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t        exp_wr_q[$];
  int         exp_irq_q[$];
  logic [7:0] frm[$];
  vec_t       vecs[13];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_strobe_cyc = 0;
  bit         irq_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pay_byte(input int k);
    logic [31:0] w;
    w = 32'hDEADBEEF;
    if (k < 4) return w[31-8*k -: 8];
    return 8'(k * 13 + 5);
  endfunction

  task automatic build_frame(input vec_t v);
    logic [15:0] ul;
    logic [15:0] tl;
    ul = 16'(v.ulen);
    tl = 16'(v.ulen + 20);
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int k = 0; k < 6; k++) frm.push_back(v.mac[47-8*k -: 8]);
    frm.push_back(8'h02); frm.push_back(8'h11); frm.push_back(8'h22);
    frm.push_back(8'h33); frm.push_back(8'h44); frm.push_back(8'h55);
    frm.push_back(v.etype[15:8]); frm.push_back(v.etype[7:0]);
    frm.push_back(8'h45); frm.push_back(8'h00); frm.push_back(tl[15:8]); frm.push_back(tl[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h01); frm.push_back(8'h00); frm.push_back(8'h00);
    frm.push_back(8'h40); frm.push_back(v.proto); frm.push_back(8'h00); frm.push_back(8'h00);
    frm.push_back(8'hC0); frm.push_back(8'hA8); frm.push_back(8'h00); frm.push_back(8'h01);
    for (int k = 0; k < 4; k++) frm.push_back(v.ip[31-8*k -: 8]);
    frm.push_back(8'h30); frm.push_back(8'h39);
    frm.push_back(v.port[15:8]); frm.push_back(v.port[7:0]);
    frm.push_back(ul[15:8]); frm.push_back(ul[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h00);
    for (int k = 0; k < v.send_pay; k++) frm.push_back(pay_byte(k));
    repeat (v.pad) frm.push_back(8'h00);
  endtask

  task automatic drive_byte(input int i, input int er_at, input int n_writes);
    wr_t e;
    @(posedge clk); #1;
    RX_DV = 1'b1;
    RXD   = frm[i];
    RX_ER = (i == er_at);
    if (i >= HDR_BYTES && (i - HDR_BYTES) < n_writes) begin
      e.addr = AW'(i - HDR_BYTES);
      e.data = frm[i];
      exp_wr_q.push_back(e);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      RX_DV = 1'b0;
      RX_ER = 1'b0;
      RXD   = 8'h00;
    end
  endtask

  task automatic send_frame(input vec_t v, input int gap);
    build_frame(v);
    if (v.exp_irq) exp_irq_q.push_back(v.exp_len);
    for (int i = 0; i < frm.size(); i++) drive_byte(i, v.er_at, v.exp_writes);
    idle_cycles(gap);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_wr_q.size() != 0 || exp_irq_q.size() != 0) && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    check("scoreboard_drained", 32'(exp_wr_q.size() + exp_irq_q.size()), 32'd0);
    exp_wr_q.delete();
    exp_irq_q.delete();
    repeat (3) @(posedge clk);
    #2;
  endtask

  function automatic vec_t mk(input logic [47:0] mac, input logic [31:0] ip,
                              input logic [15:0] port, input logic [15:0] etype,
                              input logic [7:0] proto, input int ulen, input int send_pay,
                              input int pad, input int er_at, input int exp_writes,
                              input bit exp_irq, input int exp_len, input int exp_drop);
    vec_t v;
    v.mac = mac; v.ip = ip; v.port = port; v.etype = etype; v.proto = proto;
    v.ulen = ulen; v.send_pay = send_pay; v.pad = pad; v.er_at = er_at;
    v.exp_writes = exp_writes; v.exp_irq = exp_irq; v.exp_len = exp_len;
    v.exp_drop = exp_drop;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every strobe and irq is matched against the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    int  l;
    if (!rst) begin
      if (!rx_udp_data_vb) begin
        last_strobe_cyc = cyc;
        check("wmask_on", 32'(wmask0), 32'd1);
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got addr %0d data %0h, required no write",
                   rx_addr, rx_udp_data);
        end else begin
          e = exp_wr_q.pop_front();
          check("wr_addr", 32'(rx_addr), 32'(e.addr));
          check("wr_data", 32'(rx_udp_data), 32'(e.data));
        end
      end else begin
        check("wmask_off", 32'(wmask0), 32'd0);
      end
      if (rx_irq) begin
        check("irq_width", 32'(irq_prev), 32'd0);
        if (exp_irq_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_irq: got irq with len %0d, required no irq", rx_udp_len);
        end else begin
          l = exp_irq_q.pop_front();
          check("irq_len", 32'(rx_udp_len), 32'(l));
          if (l != 0) check("irq_timing", 32'(cyc), 32'(last_strobe_cyc + 1));
        end
      end
      irq_prev = rx_irq;
    end else begin
      irq_prev = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // mac, ip, port, etype, proto, L, pay sent, pad, er_at, writes, irq, len after, drops after
    vecs[0]  = mk(MAC,   IP, 16'd1234, 16'h0800, 8'h11, 12,   4,    0, -1, 4,    1, 4,    0);
    vecs[1]  = mk(MAC,   IP, 16'd1235, 16'h0800, 8'h11, 12,   4,    0, -1, 0,    0, 4,    1);
    vecs[2]  = mk(BCAST, IP, 16'd1234, 16'h0800, 8'h11, 8,    0,    4, -1, 0,    1, 0,    1);
    vecs[3]  = mk(MAC,   IP, 16'd1234, 16'h0800, 8'h11, 1033, 10,   0, -1, 0,    0, 0,    2);
    vecs[4]  = mk(MAC,   IP, 16'd1234, 16'h0800, 8'h11, 1032, 1024, 2, -1, 1024, 1, 1024, 2);
    vecs[5]  = mk(MAC,   IP, 16'd1234, 16'h0800, 8'h11, 12,   2,    0, -1, 2,    0, 1024, 3);
    vecs[6]  = mk(MAC,   IP, 16'd1234, 16'h0800, 8'h11, 12,   4,    0, 15, 0,    0, 1024, 4);
    vecs[7]  = mk(MAC, 32'hC0A8_000B, 16'd1234, 16'h0800, 8'h11, 12, 4, 0, -1, 0, 0, 1024, 5);
    vecs[8]  = mk(48'h02_00_00_00_00_02, IP, 16'd1234, 16'h0800, 8'h11, 12, 4, 0, -1, 0, 0, 1024, 6);
    vecs[9]  = mk(MAC,   IP, 16'd1234, 16'h0800, 8'h11, 7,    0,    4, -1, 0,    0, 1024, 7);
    vecs[10] = mk(MAC,   IP, 16'd1234, 16'h0800, 8'h11, 20,   12,   6, -1, 12,   1, 12,   7);
    vecs[11] = mk(MAC,   IP, 16'd1234, 16'h86DD, 8'h11, 12,   4,    0, -1, 0,    0, 12,   8);
    vecs[12] = mk(MAC,   IP, 16'd1234, 16'h0800, 8'h06, 12,   4,    0, -1, 0,    0, 12,   9);

    rst = 1'b1; RX_DV = 1'b0; RXD = 8'h00; RX_ER = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_vb", 32'(rx_udp_data_vb), 32'd1);
    check("rst_data", 32'(rx_udp_data), 32'd0);
    check("rst_addr", 32'(rx_addr), 32'd0);
    check("rst_wmask", 32'(wmask0), 32'd0);
    check("rst_len", 32'(rx_udp_len), 32'd0);
    check("rst_irq", 32'(rx_irq), 32'd0);
    check("rst_drop", 32'(rx_drop_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(2);

    for (int t = 0; t < 13; t++) begin
      send_frame(vecs[t], 1);
      drain();
      check($sformatf("vec%0d_drop", t), 32'(rx_drop_cnt), 32'(vecs[t].exp_drop));
      check($sformatf("vec%0d_len", t), 32'(rx_udp_len), 32'(vecs[t].exp_len));
      $display("vec %0d: L=%0d writes=%0d irq=%0d len=%0d drops=%0d", t, vecs[t].ulen,
               vecs[t].exp_writes, vecs[t].exp_irq, rx_udp_len, rx_drop_cnt);
    end

    // Back-to-back frames with a single idle cycle between them.
    send_frame(mk(MAC, IP, 16'd1234, 16'h0800, 8'h11, 11, 3, 0, -1, 3, 1, 3, 9), 1);
    send_frame(mk(MAC, IP, 16'd1234, 16'h0800, 8'h11, 13, 5, 0, -1, 5, 1, 5, 9), 1);
    drain();
    check("b2b_len", 32'(rx_udp_len), 32'd5);
    check("b2b_drop", 32'(rx_drop_cnt), 32'd9);
    $display("back-to-back: len=%0d drops=%0d", rx_udp_len, rx_drop_cnt);

    // Reset in the middle of a payload, released while RX_DV is still high.
    v = mk(MAC, IP, 16'd1234, 16'h0800, 8'h11, 16, 8, 0, -1, 3, 0, 0, 0);
    build_frame(v);
    for (int i = 0; i < HDR_BYTES + 3; i++) drive_byte(i, -1, 3);
    @(posedge clk);
    #6;
    rst = 1'b1;
    #1;
    check("midrst_vb", 32'(rx_udp_data_vb), 32'd1);
    check("midrst_wmask", 32'(wmask0), 32'd0);
    check("midrst_addr", 32'(rx_addr), 32'd0);
    check("midrst_data", 32'(rx_udp_data), 32'd0);
    check("midrst_len", 32'(rx_udp_len), 32'd0);
    check("midrst_drop", 32'(rx_drop_cnt), 32'd0);
    for (int i = HDR_BYTES + 3; i < frm.size(); i++) begin
      drive_byte(i, -1, 0);
      if (i == HDR_BYTES + 5) rst = 1'b0;
    end
    idle_cycles(1);
    drain();
    check("postrst_drop", 32'(rx_drop_cnt), 32'd0);
    check("postrst_len", 32'(rx_udp_len), 32'd0);
    $display("mid-payload reset: len=%0d drops=%0d", rx_udp_len, rx_drop_cnt);

    send_frame(mk(MAC, IP, 16'd1234, 16'h0800, 8'h11, 10, 2, 3, -1, 2, 1, 2, 0), 1);
    drain();
    check("after_rst_len", 32'(rx_udp_len), 32'd2);
    check("after_rst_drop", 32'(rx_drop_cnt), 32'd0);
    $display("frame after reset: len=%0d drops=%0d", rx_udp_len, rx_drop_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
